vector_alu_seq: RTL and testbench

Vector execute stage sitting directly downstream of `vector_control_unit`. It accepts one vector instruction's decoded controls (`ALU_Vectorial`, `Vect_Write`, destination index) together with two packed operand vectors. It computes lane-wise add, subtract, multiply or pass-through and presents the result with write-back controls to the vector register file. Add, subtract and pass complete in one cycle; multiply iterates one lane per cycle through a single shared multiplier.

---
 rtl/vector_alu_seq.sv | 119 +++++++++++
 tb/tb_vector_alu_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_alu_seq.sv
// Vector execute stage: lane-wise add/sub/pass in one cycle,
// multiply iterated one lane per cycle through a shared multiplier.
module vector_alu_seq #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              ALU_Vectorial,
    input  logic                    Vect_Write,
    input  logic [IDX_W-1:0]        dst_idx,
    input  logic [LANES*DATA_W-1:0] src_a,
    input  logic [LANES*DATA_W-1:0] src_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] result,
    output logic                    wb_en,
    output logic [IDX_W-1:0]        wb_idx,
    output logic                    busy
);

    localparam int VW = LANES * DATA_W;
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [VW-1:0]     a_q;
    logic [VW-1:0]     b_q;
    logic [VW-1:0]     alu_res;
    logic              vw_q;
    logic [DATA_W-1:0] a_lane;
    logic [DATA_W-1:0] b_lane;
    logic [DATA_W-1:0] prod;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign wb_en     = out_valid & vw_q;

    // Only the low DATA_W bits of each product are kept.
    assign a_lane = a_q[cnt*DATA_W +: DATA_W];
    assign b_lane = b_q[cnt*DATA_W +: DATA_W];
    assign prod   = a_lane * b_lane;

    always_comb begin
        alu_res = '0;
        for (int i = 0; i < LANES; i++) begin
            case (ALU_Vectorial)
                2'b00:
                    alu_res[i*DATA_W +: DATA_W] =
                        src_a[i*DATA_W +: DATA_W] +
                        src_b[i*DATA_W +: DATA_W];
                2'b01:
                    alu_res[i*DATA_W +: DATA_W] =
                        src_a[i*DATA_W +: DATA_W] -
                        src_b[i*DATA_W +: DATA_W];
                default:
                    alu_res[i*DATA_W +: DATA_W] =
                        src_b[i*DATA_W +: DATA_W];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            result <= '0;
            a_q    <= '0;
            b_q    <= '0;
            vw_q   <= 1'b0;
            wb_idx <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= src_a;
                        b_q    <= src_b;
                        vw_q   <= Vect_Write;
                        wb_idx <= dst_idx;
                        cnt    <= '0;
                        if (ALU_Vectorial == 2'b10) begin
                            result <= '0;
                            state  <= MUL;
                        end else begin
                            result <= alu_res;
                            state  <= DONE;
                        end
                    end
                end
                MUL: begin
                    result[cnt*DATA_W +: DATA_W] <= prod;
                    if (cnt == LAST) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_alu_seq.sv
// Directed testbench for vector_alu_seq with hand-computed vectors.
module tb_vector_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ALU_Vectorial;
    logic        Vect_Write;
    logic [3:0]  dst_idx;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        wb_en;
    logic [3:0]  wb_idx;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    vector_alu_seq #(.LANES(4), .DATA_W(8), .IDX_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .ALU_Vectorial(ALU_Vectorial),
        .Vect_Write(Vect_Write),
        .dst_idx(dst_idx),
        .src_a(src_a),
        .src_b(src_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .wb_en(wb_en),
        .wb_idx(wb_idx),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] v4(input int l0, input int l1,
                                       input int l2, input int l3);
        logic [31:0] v;
        v = {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic vw,
                         input logic [3:0] d);
        in_valid      = 1'b1;
        ALU_Vectorial = op;
        src_a         = a;
        src_b         = b;
        Vect_Write    = vw;
        dst_idx       = d;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        issue(2'b00, v4(1, 2, 3, 4), v4(1, 1, 1, 1), 1'b1, 4'd7);
        step();
        step();
        n_checks++;
        if (out_valid !== 1'b0 || wb_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: out_valid=%b wb_en=%b busy=%b want 0 0 0",
                     out_valid, wb_en, busy);
        end
        n_checks++;
        if (result !== 32'h0 || wb_idx !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_data: result=%h wb_idx=%h want 0 0",
                     result, wb_idx);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_no_accept: out_valid=%b in_ready=%b want 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_vadd();
        out_ready = 1'b1;
        issue(2'b00, v4(10, 20, 30, 40), v4(1, 2, 3, 250), 1'b1, 4'd5);
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || result !== v4(11, 22, 33, 34)) begin
            n_fail++;
            $display("FAIL vadd_result: valid=%b result=%h want 1 %h",
                     out_valid, result, v4(11, 22, 33, 34));
        end
        n_checks++;
        if (wb_en !== 1'b1 || wb_idx !== 4'd5 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL vadd_wb: wb_en=%b wb_idx=%0d in_ready=%b want 1 5 0",
                     wb_en, wb_idx, in_ready);
        end
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || wb_en !== 1'b0) begin
            n_fail++;
            $display("FAIL vadd_idle: in_ready=%b out_valid=%b wb_en=%b want 1 0 0",
                     in_ready, out_valid, wb_en);
        end
    endtask

    task automatic test_vsub_pass();
        issue(2'b01, v4(5, 0, 100, 9), v4(6, 1, 50, 9), 1'b1, 4'd2);
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || result !== v4(255, 255, 50, 0)) begin
            n_fail++;
            $display("FAIL vsub_result: valid=%b result=%h want 1 %h",
                     out_valid, result, v4(255, 255, 50, 0));
        end
        step();
        issue(2'b11, v4(1, 1, 1, 1), v4(7, 8, 9, 10), 1'b0, 4'd3);
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || result !== v4(7, 8, 9, 10)) begin
            n_fail++;
            $display("FAIL pass_result: valid=%b result=%h want 1 %h",
                     out_valid, result, v4(7, 8, 9, 10));
        end
        n_checks++;
        if (wb_en !== 1'b0 || wb_idx !== 4'd3) begin
            n_fail++;
            $display("FAIL pass_wb: wb_en=%b wb_idx=%0d want 0 3", wb_en, wb_idx);
        end
        step();
    endtask

    task automatic test_vmul();
        issue(2'b10, v4(3, 16, 255, 0), v4(7, 16, 2, 9), 1'b1, 4'd11);
        step();
        in_valid = 1'b0;
        n_checks++;
        if (result !== 32'h0) begin
            n_fail++;
            $display("FAIL vmul_clear: result=%h want 0", result);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL vmul_busy[%0d]: busy=%b in_ready=%b out_valid=%b want 1 0 0",
                         i, busy, in_ready, out_valid);
            end
            step();
        end
        n_checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL vmul_done: out_valid=%b busy=%b in_ready=%b want 1 1 0",
                     out_valid, busy, in_ready);
        end
        n_checks++;
        if (result !== v4(21, 0, 254, 0) || wb_en !== 1'b1 || wb_idx !== 4'd11) begin
            n_fail++;
            $display("FAIL vmul_result: result=%h wb_en=%b wb_idx=%0d want %h 1 11",
                     result, wb_en, wb_idx, v4(21, 0, 254, 0));
        end
        step();
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL vmul_idle: in_ready=%b busy=%b want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        issue(2'b00, v4(1, 2, 3, 4), v4(1, 1, 1, 1), 1'b1, 4'd6);
        step();
        issue(2'b01, v4(9, 9, 9, 9), v4(1, 2, 3, 4), 1'b1, 4'd12);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (result !== v4(2, 3, 4, 5) || in_ready !== 1'b0 ||
                out_valid !== 1'b1 || wb_idx !== 4'd6) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: result=%h in_ready=%b valid=%b idx=%0d want %h 0 1 6",
                         i, result, in_ready, out_valid, wb_idx, v4(2, 3, 4, 5));
            end
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0",
                     in_ready, out_valid);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || result !== v4(8, 7, 6, 5) || wb_idx !== 4'd12) begin
            n_fail++;
            $display("FAIL bp_next: valid=%b result=%h idx=%0d want 1 %h 12",
                     out_valid, result, wb_idx, v4(8, 7, 6, 5));
        end
        step();
    endtask

    task automatic test_reset_mid_mul();
        issue(2'b10, v4(2, 3, 4, 5), v4(2, 3, 4, 5), 1'b1, 4'd13);
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            wb_en !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_ctl: in_ready=%b valid=%b busy=%b wb_en=%b want 1 0 0 0",
                     in_ready, out_valid, busy, wb_en);
        end
        n_checks++;
        if (result !== 32'h0 || wb_idx !== 4'h0) begin
            n_fail++;
            $display("FAIL midrst_data: result=%h wb_idx=%h want 0 0", result, wb_idx);
        end
        rst_n = 1'b1;
        issue(2'b00, v4(100, 200, 1, 2), v4(100, 100, 255, 3), 1'b1, 4'd9);
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || result !== v4(200, 44, 0, 5) ||
            wb_en !== 1'b1 || wb_idx !== 4'd9) begin
            n_fail++;
            $display("FAIL midrst_vadd: valid=%b result=%h wb_en=%b idx=%0d want 1 %h 1 9",
                     out_valid, result, wb_en, wb_idx, v4(200, 44, 0, 5));
        end
        step();
    endtask

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        ALU_Vectorial = 2'b00;
        Vect_Write    = 1'b0;
        dst_idx       = 4'h0;
        src_a         = 32'h0;
        src_b         = 32'h0;
        out_ready     = 1'b0;
        #1;
        test_reset();
        test_vadd();
        test_vsub_pass();
        test_vmul();
        test_backpressure();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
